fifo_full_ctrl: RTL
===================

Name: fifo_full_ctrl

Overview:
Write-side pointer and status controller for the async FIFO. It is the counterpart of the read-side empty controller. It keeps the binary write address and the Gray-coded write pointer, and generates registered full and almost-full flags. It also provides a conservative fill level by comparing against the read pointer already synchronized into the write clock domain. The block sits in the write clock domain between the producer, the dual-port RAM write port and the read-to-write pointer synchronizer.

Parameters:
address_Size, 3, RAM address width. Depth = 2^address_Size. Must be >= 2.
almost_Full_Thresh, 7, level at or above which fifo_AlmostFull asserts. Legal range 1..2^address_Size.

Ports:
w_Clk  input  1  write-domain clock; all logic on its rising edge
w_Rst  input  1  write-domain reset, synchronous, active-high
w_Inc  input  1  write request from producer
wsync_Rptr  input  address_Size+1  Gray read pointer, already synchronized to w_Clk
w_Addr  output  address_Size  RAM write address (low bits of binary write counter)
w_Ptr  output  address_Size+1  registered Gray write pointer, sent to the synchronizer
fifo_Full  output  1  registered full flag
fifo_AlmostFull  output  1  registered almost-full flag
w_Level  output  address_Size+1  registered fill level, 0..2^address_Size
w_Overflow  output  1  sticky overflow error; see Optional Feature

Behaviour:
- Reset: w_Rst=1 sampled at a w_Clk edge drives the following state at that edge:
  - w_Bin=0, w_Ptr=0
  - fifo_Full=0, fifo_AlmostFull=0
  - w_Level=0, w_Overflow=0
- Reset has priority over everything, including mid-burst and while full.
- Write qualification:
  - wr_en = w_Inc & ~fifo_Full, using the registered flag from the current cycle.
  - A write attempted while full is dropped: w_Bin and w_Ptr hold.
- w_BinNext = w_Bin + wr_en, modulo 2^(address_Size+1).
- w_GrayNext = (w_BinNext>>1) ^ w_BinNext.
- w_Bin and w_Ptr load w_BinNext and w_GrayNext each cycle.
- w_Addr = w_Bin[address_Size-1:0], combinational from the register. It is valid in the same cycle w_Inc is presented.
- Full:
  - full_next is true when w_GrayNext == {~wsync_Rptr[address_Size:address_Size-1], wsync_Rptr[address_Size-2:0]}.
  - fifo_Full is registered from full_next, so it asserts on the same edge as the write that fills the last slot.
- Level:
  - rsync_Bin is the Gray-to-binary conversion of wsync_Rptr, computed with an XOR prefix from the MSB down.
  - w_LevelNext = w_BinNext - rsync_Bin, modulo 2^(address_Size+1). It is registered into w_Level.
  - The level over-estimates occupancy by the synchronizer lag and never under-estimates it.
- Almost full: fifo_AlmostFull is registered from (w_LevelNext >= almost_Full_Thresh).
- Full deassertion: fifo_Full deasserts on the first edge after wsync_Rptr advances. Flag-release latency from the wsync_Rptr change is 1 w_Clk.
- Wrap-around: the binary counter wraps from 2^(address_Size+1)-1 to 0 with no special case. The extra MSB distinguishes full from empty.
- Simultaneous write and read-pointer advance in the same cycle: both are applied. Level stays consistent.
- No handshake stall: the producer must observe fifo_Full before asserting w_Inc.

Optional Feature:
Macro FIFO_OVERFLOW_FLAG_EN.
- Defined: w_Overflow is a sticky register. It is set on any edge where w_Inc=1 and fifo_Full=1, and is cleared only by w_Rst.
- Undefined: w_Overflow is tied to 0, the port remains present and no register is generated.

Test Plan:
1. Reset: address_Size=3, hold w_Rst=1 for 2 edges with w_Inc=1 -> w_Addr=0, w_Ptr=4'b0000, fifo_Full=0, fifo_AlmostFull=0, w_Level=0, w_Overflow=0.
2. Fill: wsync_Rptr=0, w_Inc=1 for 8 edges -> after edge 7: w_Level=7, fifo_AlmostFull=1, fifo_Full=0. After edge 8: fifo_Full=1, w_Ptr=4'b1100, w_Addr=0, w_Level=8.
3. Write while full: keep w_Inc=1 for 3 more edges -> w_Ptr stays 4'b1100, w_Addr stays 0, fifo_Full=1. w_Overflow=1 with the macro, 0 without it.
4. Drain release: w_Inc=0, set wsync_Rptr=4'b0010 (binary 3) -> next edge fifo_Full=0, w_Level=5, fifo_AlmostFull=0.
5. Wrap-around: stream 40 writes while a model advances wsync_Rptr 2 cycles behind. Check:
   - w_Addr wraps 7->0.
   - w_Ptr changes exactly one bit per write.
   - fifo_Full is asserted exactly when the writer is 8 entries ahead.
   - w_Level matches the model every cycle.
6. Reset mid-operation: assert w_Rst for 1 edge while fifo_Full=1 and w_Overflow=1 -> all outputs return to 0 on that edge, and writes resume from w_Addr=0.

Source files
------------

// File: rtl/fifo_full_ctrl.sv
// fifo_full_ctrl: write-side pointer and status controller for an async FIFO.
// Holds the binary and Gray write counters and produces registered full,
// almost-full and a conservative fill level against the synchronized read
// pointer.
// Optional macro FIFO_OVERFLOW_FLAG_EN enables the sticky overflow register.
// Ports:
//   w_Clk, w_Rst        write clock, sync active-high reset
//   w_Inc               producer write request
//   wsync_Rptr          Gray read pointer synchronized into w_Clk
//   w_Addr              RAM write address
//   w_Ptr               Gray write pointer to the synchronizer
//   fifo_Full           registered full flag
//   fifo_AlmostFull     registered almost-full flag
//   w_Level             registered fill level, 0..2^address_Size
//   w_Overflow          sticky write-while-full error (0 when macro undefined)
module fifo_full_ctrl #(
  parameter int address_Size       = 3,
  parameter int almost_Full_Thresh = 7
) (
  input  logic                    w_Clk,
  input  logic                    w_Rst,
  input  logic                    w_Inc,
  input  logic [address_Size:0]   wsync_Rptr,
  output logic [address_Size-1:0] w_Addr,
  output logic [address_Size:0]   w_Ptr,
  output logic                    fifo_Full,
  output logic                    fifo_AlmostFull,
  output logic [address_Size:0]   w_Level,
  output logic                    w_Overflow
);

  localparam int AW = address_Size;
  localparam logic [AW:0] THRESH = (AW+1)'(almost_Full_Thresh);

  logic [AW:0] w_Bin;
  logic [AW:0] w_BinNext;
  logic [AW:0] w_GrayNext;
  logic [AW:0] rsync_Bin;
  logic [AW:0] w_LevelNext;
  logic        wr_en;
  logic        full_next;
  logic        af_next;

  // XOR prefix from the MSB down
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    wr_en       = w_Inc & ~fifo_Full;
    w_BinNext   = w_Bin + {{AW{1'b0}}, wr_en};
    w_GrayNext  = (w_BinNext >> 1) ^ w_BinNext;
    // Full when the writer is one lap ahead: top two Gray bits inverted
    full_next   = (w_GrayNext ==
                   {~wsync_Rptr[AW:AW-1], wsync_Rptr[AW-2:0]});
    rsync_Bin   = gray2bin(wsync_Rptr);
    // Stale read pointer makes this an over-estimate, never an under-estimate
    w_LevelNext = w_BinNext - rsync_Bin;
    af_next     = (w_LevelNext >= THRESH);
  end

  always_ff @(posedge w_Clk) begin
    if (w_Rst) begin
      w_Bin           <= '0;
      w_Ptr           <= '0;
      fifo_Full       <= 1'b0;
      fifo_AlmostFull <= 1'b0;
      w_Level         <= '0;
    end else begin
      w_Bin           <= w_BinNext;
      w_Ptr           <= w_GrayNext;
      fifo_Full       <= full_next;
      fifo_AlmostFull <= af_next;
      w_Level         <= w_LevelNext;
    end
  end

  assign w_Addr = w_Bin[AW-1:0];

`ifdef FIFO_OVERFLOW_FLAG_EN
  always_ff @(posedge w_Clk) begin
    if (w_Rst) begin
      w_Overflow <= 1'b0;
    end else if (w_Inc && fifo_Full) begin
      w_Overflow <= 1'b1;
    end
  end
`else
  assign w_Overflow = 1'b0;
`endif

endmodule
